inst_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode/execute logic and drives the instruction-read side of the RAM. It holds the program counter (PC), issues single-cycle instruction reads, captures the registered RAM instruction output one cycle later, and splits it into opcode and register fields. It presents each instruction to the consumer through a valid/ready handshake. It also accepts branch redirects that cancel any in-flight fetch.

---
 rtl/inst_fetch.sv | 124 ++++++++++++
 tb/tb_inst_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
//------------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. It holds the program counter and issues one
// single-cycle read to the instruction RAM. One cycle later it captures the
// registered RAM output and splits it into opcode and register fields. The
// instruction is then held on a valid/ready handshake until the consumer
// takes it. A branch redirect cancels any fetch that is still in flight.
//
// Parameters:
//   ADDR_WIDTH  PC / RAM address width
//   INST_WIDTH  instruction width: opcode[20:18] src1[17:12] src2[11:6] dest[5:0]
//   RESET_PC    PC value loaded on reset
//
// Ports:
//   Clk, Rst_n      clock (rising edge), asynchronous active-low reset
//   Fetch_En        permits new fetches
//   Branch_Load     one-cycle redirect request, highest priority
//   Branch_Addr     redirect target
//   Ram_Inst_Out    registered instruction data from the RAM
//   Ram_Inst_Read   read strobe to the RAM (high only in the request cycle)
//   Fetch_Addr      RAM address, always equal to the PC
//   Inst_Valid      instruction fields are valid
//   Inst_Ready      consumer accepts the instruction
//   Inst_Opcode, Inst_Src1, Inst_Src2, Inst_Dest   decoded fields
//   Inst_PC         address the presented instruction was fetched from
//   Fetch_Busy      high whenever a fetch is in progress or being presented
//------------------------------------------------------------------------------
module inst_fetch #(
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    INST_WIDTH = 21,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Fetch_En,
   input  logic                  Branch_Load,
   input  logic [ADDR_WIDTH-1:0] Branch_Addr,
   input  logic [INST_WIDTH-1:0] Ram_Inst_Out,
   output logic                  Ram_Inst_Read,
   output logic [ADDR_WIDTH-1:0] Fetch_Addr,
   output logic                  Inst_Valid,
   input  logic                  Inst_Ready,
   output logic [2:0]            Inst_Opcode,
   output logic [5:0]            Inst_Src1,
   output logic [5:0]            Inst_Src2,
   output logic [5:0]            Inst_Dest,
   output logic [ADDR_WIDTH-1:0] Inst_PC,
   output logic                  Fetch_Busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_CAPT  = 2'd2;
   localparam logic [1:0] ST_VALID = 2'd3;

   logic [1:0]            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
   logic                  capture;
   logic [2:0]            opcode_reg;
   logic [5:0]            src1_reg, src2_reg, dest_reg;
   logic [ADDR_WIDTH-1:0] inst_pc_reg;

   // A branch overrides every state. Leaving CAPT through a branch means the
   // capture never happens, so the pending RAM data is dropped. Leaving VALID
   // through a branch also drops Inst_Valid. If Inst_Ready is high on that
   // edge, the consumer has already taken the instruction, so nothing is lost.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      capture    = 1'b0;
      if (Branch_Load) begin
         pc_next    = Branch_Addr;
         state_next = Fetch_En ? ST_REQ : ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:  if (Fetch_En) state_next = ST_REQ;
            ST_REQ:   state_next = ST_CAPT;
            ST_CAPT: begin
               state_next = ST_VALID;
               capture    = 1'b1;
               // The PC advances here, not at the handshake. The next fetch
               // can then start straight from VALID with no extra cycle.
               pc_next    = pc_reg + ADDR_WIDTH'(1);
            end
            ST_VALID: if (Inst_Ready) state_next = Fetch_En ? ST_REQ : ST_IDLE;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg   <= ST_IDLE;
         pc_reg      <= RESET_PC;
         opcode_reg  <= '0;
         src1_reg    <= '0;
         src2_reg    <= '0;
         dest_reg    <= '0;
         inst_pc_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         if (capture) begin
            opcode_reg  <= Ram_Inst_Out[20:18];
            src1_reg    <= Ram_Inst_Out[17:12];
            src2_reg    <= Ram_Inst_Out[11:6];
            dest_reg    <= Ram_Inst_Out[5:0];
            inst_pc_reg <= pc_reg;
         end
      end
   end

   assign Ram_Inst_Read = (state_reg == ST_REQ);
   assign Fetch_Addr    = pc_reg;
   assign Inst_Valid    = (state_reg == ST_VALID);
   assign Fetch_Busy    = (state_reg != ST_IDLE);
   assign Inst_Opcode   = opcode_reg;
   assign Inst_Src1     = src1_reg;
   assign Inst_Src2     = src2_reg;
   assign Inst_Dest     = dest_reg;
   assign Inst_PC       = inst_pc_reg;

endmodule

// File: tb/tb_inst_fetch.sv
//------------------------------------------------------------------------------
// tb_inst_fetch
//
// Bench for inst_fetch. A behavioural RAM with a registered read feeds the
// design. Directed scenario tasks run first, then a randomized run. The
// randomized run is checked against the ordered sequence of instruction
// addresses the consumer should receive.
//------------------------------------------------------------------------------
module tb_inst_fetch;

   localparam int AW = 6;
   localparam int IW = 21;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          Fetch_En = 1'b0;
   logic          Branch_Load = 1'b0;
   logic [AW-1:0] Branch_Addr = '0;
   logic [IW-1:0] Ram_Inst_Out = '0;
   logic          Ram_Inst_Read;
   logic [AW-1:0] Fetch_Addr;
   logic          Inst_Valid;
   logic          Inst_Ready = 1'b0;
   logic [2:0]    Inst_Opcode;
   logic [5:0]    Inst_Src1, Inst_Src2, Inst_Dest;
   logic [AW-1:0] Inst_PC;
   logic          Fetch_Busy;

   int checks = 0;
   int errors = 0;

   logic [IW-1:0] mem [64];

   inst_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC('0)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Fetch_En(Fetch_En), .Branch_Load(Branch_Load),
      .Branch_Addr(Branch_Addr), .Ram_Inst_Out(Ram_Inst_Out),
      .Ram_Inst_Read(Ram_Inst_Read), .Fetch_Addr(Fetch_Addr),
      .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
      .Inst_Opcode(Inst_Opcode), .Inst_Src1(Inst_Src1), .Inst_Src2(Inst_Src2),
      .Inst_Dest(Inst_Dest), .Inst_PC(Inst_PC), .Fetch_Busy(Fetch_Busy)
   );

   always #5 Clk = ~Clk;

   // Registered-read RAM. With no read strobe the output is garbage, so any
   // data captured outside a real fetch shows up as a wrong field value.
   always @(posedge Clk)
      Ram_Inst_Out <= Ram_Inst_Read ? mem[Fetch_Addr] : IW'($urandom);

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [IW-1:0] fields();
      return {Inst_Opcode, Inst_Src1, Inst_Src2, Inst_Dest};
   endfunction

   task automatic test_reset();
      Rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({Inst_Valid, fields(), Inst_PC, Ram_Inst_Read, Fetch_Busy, Fetch_Addr} !== '0) begin
         errors++;
         $display("FAIL reset_state got v=%0b f=%h pc=%0d rd=%0b busy=%0b fa=%0d want all 0",
                  Inst_Valid, fields(), Inst_PC, Ram_Inst_Read, Fetch_Busy, Fetch_Addr);
      end
      #4 Rst_n = 1'b1;
      tick();
      checks++;
      if ({Fetch_Busy, Ram_Inst_Read} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle got busy=%0b rd=%0b want 0 0", Fetch_Busy, Ram_Inst_Read);
      end
   endtask

   task automatic test_stream();
      Fetch_En   = 1'b1;
      Inst_Ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         checks++;
         if ({Ram_Inst_Read, Inst_Valid} !== {k % 3 == 0, k % 3 == 2}) begin
            errors++;
            $display("FAIL stream_cycle%0d got rd=%0b v=%0b want rd=%0b v=%0b", k,
                     Ram_Inst_Read, Inst_Valid, k % 3 == 0, k % 3 == 2);
         end
         if (k % 3 == 0) begin
            checks++;
            if (Fetch_Addr !== AW'(k / 3)) begin
               errors++;
               $display("FAIL stream_addr%0d got %0d want %0d", k, Fetch_Addr, k / 3);
            end
         end
         if (k % 3 == 2) begin
            checks++;
            if ({Inst_PC, fields()} !== {AW'(k / 3), mem[k / 3]}) begin
               errors++;
               $display("FAIL stream_inst%0d got pc=%0d f=%h want pc=%0d f=%h", k,
                        Inst_PC, fields(), k / 3, mem[k / 3]);
            end
         end
         if (k == 2) begin
            checks++;
            if ({Inst_Opcode, Inst_Src1, Inst_Src2, Inst_Dest} !== {3'd7, 6'd1, 6'd2, 6'd3}) begin
               errors++;
               $display("FAIL decode got op=%0d s1=%0d s2=%0d d=%0d want 7 1 2 3",
                        Inst_Opcode, Inst_Src1, Inst_Src2, Inst_Dest);
            end
         end
      end
      Fetch_En = 1'b0;
      tick();
      checks++;
      if ({Fetch_Busy, Inst_Valid} !== 2'b00) begin
         errors++;
         $display("FAIL stream_idle got busy=%0b v=%0b want 0 0", Fetch_Busy, Inst_Valid);
      end
   endtask

   task automatic test_stall();
      logic [IW-1:0] held;
      Fetch_En   = 1'b1;
      Inst_Ready = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({Inst_Valid, Inst_PC, fields()} !== {1'b1, AW'(3), mem[3]}) begin
         errors++;
         $display("FAIL stall_first got v=%0b pc=%0d f=%h want 1 3 %h",
                  Inst_Valid, Inst_PC, fields(), mem[3]);
      end
      held = fields();
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if ({Inst_Valid, Inst_PC, fields(), Ram_Inst_Read, Fetch_Addr} !==
             {1'b1, AW'(3), held, 1'b0, AW'(4)}) begin
            errors++;
            $display("FAIL stall_hold%0d got v=%0b pc=%0d f=%h rd=%0b fa=%0d want 1 3 %h 0 4",
                     k, Inst_Valid, Inst_PC, fields(), Ram_Inst_Read, Fetch_Addr, held);
         end
      end
      Inst_Ready = 1'b1;
      tick();
      checks++;
      if ({Inst_Valid, Ram_Inst_Read, Fetch_Addr} !== {1'b0, 1'b1, AW'(4)}) begin
         errors++;
         $display("FAIL stall_release got v=%0b rd=%0b fa=%0d want 0 1 4",
                  Inst_Valid, Ram_Inst_Read, Fetch_Addr);
      end
   endtask

   // Entered while a fetch from address 4 is in REQ; the branch discards it.
   task automatic test_wrap();
      Branch_Load = 1'b1;
      Branch_Addr = AW'(63);
      Fetch_En    = 1'b1;
      Inst_Ready  = 1'b1;
      tick();
      Branch_Load = 1'b0;
      checks++;
      if ({Ram_Inst_Read, Fetch_Addr} !== {1'b1, AW'(63)}) begin
         errors++;
         $display("FAIL wrap_req got rd=%0b fa=%0d want 1 63", Ram_Inst_Read, Fetch_Addr);
      end
      tick();
      tick();
      checks++;
      if ({Inst_Valid, Inst_PC, fields()} !== {1'b1, AW'(63), mem[63]}) begin
         errors++;
         $display("FAIL wrap_inst got v=%0b pc=%0d f=%h want 1 63 %h",
                  Inst_Valid, Inst_PC, fields(), mem[63]);
      end
      tick();
      checks++;
      if ({Ram_Inst_Read, Fetch_Addr} !== {1'b1, AW'(0)}) begin
         errors++;
         $display("FAIL wrap_next got rd=%0b fa=%0d want 1 0", Ram_Inst_Read, Fetch_Addr);
      end
   endtask

   task automatic test_branch_capt();
      Branch_Load = 1'b1;
      Branch_Addr = AW'(4);
      Fetch_En    = 1'b1;
      Inst_Ready  = 1'b1;
      tick();
      Branch_Load = 1'b0;
      tick();
      Branch_Load = 1'b1;
      Branch_Addr = AW'(10);
      tick();
      Branch_Load = 1'b0;
      checks++;
      if ({Ram_Inst_Read, Fetch_Addr, Inst_Valid} !== {1'b1, AW'(10), 1'b0}) begin
         errors++;
         $display("FAIL branch_req got rd=%0b fa=%0d v=%0b want 1 10 0",
                  Ram_Inst_Read, Fetch_Addr, Inst_Valid);
      end
      tick();
      checks++;
      if (Inst_Valid !== 1'b0) begin
         errors++;
         $display("FAIL branch_capt got v=%0b want 0", Inst_Valid);
      end
      tick();
      checks++;
      if ({Inst_Valid, Inst_PC, fields()} !== {1'b1, AW'(10), mem[10]}) begin
         errors++;
         $display("FAIL branch_inst got v=%0b pc=%0d f=%h want 1 10 %h",
                  Inst_Valid, Inst_PC, fields(), mem[10]);
      end
      Fetch_En = 1'b0;
      tick();
   endtask

   task automatic test_drop_en();
      Fetch_En   = 1'b1;
      Inst_Ready = 1'b1;
      tick();
      tick();
      Fetch_En = 1'b0;
      tick();
      checks++;
      if ({Inst_Valid, Fetch_Busy, Inst_PC, fields()} !== {1'b1, 1'b1, AW'(11), mem[11]}) begin
         errors++;
         $display("FAIL dropen_inst got v=%0b busy=%0b pc=%0d f=%h want 1 1 11 %h",
                  Inst_Valid, Fetch_Busy, Inst_PC, fields(), mem[11]);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({Inst_Valid, Fetch_Busy, Ram_Inst_Read} !== 3'b000) begin
            errors++;
            $display("FAIL dropen_idle%0d got v=%0b busy=%0b rd=%0b want 0 0 0",
                     k, Inst_Valid, Fetch_Busy, Ram_Inst_Read);
         end
      end
   endtask

   task automatic test_async_reset();
      Fetch_En   = 1'b1;
      Inst_Ready = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({Inst_Valid, Inst_PC} !== {1'b1, AW'(12)}) begin
         errors++;
         $display("FAIL areset_pre got v=%0b pc=%0d want 1 12", Inst_Valid, Inst_PC);
      end
      #3 Rst_n = 1'b0;
      #1;
      checks++;
      if ({Inst_Valid, fields(), Inst_PC, Fetch_Addr, Fetch_Busy, Ram_Inst_Read} !== '0) begin
         errors++;
         $display("FAIL areset_now got v=%0b f=%h pc=%0d fa=%0d busy=%0b rd=%0b want all 0",
                  Inst_Valid, fields(), Inst_PC, Fetch_Addr, Fetch_Busy, Ram_Inst_Read);
      end
      Fetch_En = 1'b0;
      #3 Rst_n = 1'b1;
      tick();
      checks++;
      if ({Inst_Valid, Fetch_Busy, Fetch_Addr} !== {1'b0, 1'b0, AW'(0)}) begin
         errors++;
         $display("FAIL areset_after got v=%0b busy=%0b fa=%0d want 0 0 0",
                  Inst_Valid, Fetch_Busy, Fetch_Addr);
      end
   endtask

   // Reference model: the consumer must see addresses exp_pc, exp_pc+1, ...
   // in order. A branch replaces the rest of that sequence with its target.
   task automatic test_random();
      logic [AW-1:0] exp_pc = '0;
      logic          pre_valid, hold;
      logic [IW-1:0] pre_fields;
      logic [AW-1:0] pre_pc;
      int            handshakes = 0;
      for (int c = 0; c < 400; c++) begin
         pre_valid   = Inst_Valid;
         pre_fields  = fields();
         pre_pc      = Inst_PC;
         Fetch_En    = ($urandom_range(0, 9) < 7);
         Inst_Ready  = ($urandom_range(0, 9) < 6);
         Branch_Load = ($urandom_range(0, 11) == 0);
         Branch_Addr = AW'($urandom);
         if (pre_valid && Inst_Ready) begin
            checks++;
            if ({pre_pc, pre_fields} !== {exp_pc, mem[exp_pc]}) begin
               errors++;
               $display("FAIL rand_deliver c=%0d got pc=%0d f=%h want pc=%0d f=%h",
                        c, pre_pc, pre_fields, exp_pc, mem[exp_pc]);
            end
            exp_pc = exp_pc + AW'(1);
            handshakes++;
         end
         if (Branch_Load) exp_pc = Branch_Addr;
         hold = pre_valid && !Inst_Ready && !Branch_Load;
         tick();
         if (hold) begin
            checks++;
            if ({Inst_Valid, Inst_PC, fields()} !== {1'b1, pre_pc, pre_fields}) begin
               errors++;
               $display("FAIL rand_hold c=%0d got v=%0b pc=%0d f=%h want 1 %0d %h",
                        c, Inst_Valid, Inst_PC, fields(), pre_pc, pre_fields);
            end
         end
         if (Ram_Inst_Read) begin
            checks++;
            if (Fetch_Addr !== exp_pc) begin
               errors++;
               $display("FAIL rand_addr c=%0d got %0d want %0d", c, Fetch_Addr, exp_pc);
            end
         end
      end
      Branch_Load = 1'b0;
      checks++;
      if (handshakes < 20) begin
         errors++;
         $display("FAIL rand_progress got %0d handshakes want at least 20", handshakes);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = IW'($urandom) | 21'h100000;
      mem[0]  = 21'h1C1083;
      mem[1]  = 21'h040000;
      mem[2]  = 21'h0A0041;
      mem[4]  = 21'h1FFFFF;
      mem[10] = 21'h12345A;
      test_reset();
      test_stream();
      test_stall();
      test_wrap();
      test_branch_capt();
      test_drop_en();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
